regbank_ctx: RTL and testbench

Integer register bank for the hf-risc core: 31 general-purpose 32-bit registers plus hardwired-zero x0, two combinational read ports and one write port, extended with a context save/restore engine. The engine streams r1..r31 out over a valid/ready port (save) or loads them from one (restore), so the interrupt/trap unit can spill and refill the architectural state without using the pipeline. It sits in the decode stage in place of the plain register bank and drives the same read/write interface.

---
 rtl/regbank_ctx.sv | 157 +++++++++++++++
 tb/tb_regbank_ctx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_ctx.sv
`default_nettype none
// ============================================================================
// Module   : regbank_ctx
// Purpose  : Integer register bank for the hf-risc core.
//            - x0 hardwired to zero, r1..r31 are 32-bit registers.
//            - Two combinational read ports and one pipeline write port.
//            - A context engine streams r1..r31 out (save) or in (restore)
//              over valid/ready ports without using the pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1   core clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   wreg         in   1   pipeline write enable (honoured only when idle)
//   write_reg    in   5   pipeline write address
//   write_data   in   32  pipeline write data
//   read_reg1/2  in   5   read port addresses
//   read_data1/2 out  32  read port data (combinational, no write bypass)
//   ctx_save     in   1   start save request (sampled when idle)
//   ctx_restore  in   1   start restore request (sampled when idle)
//   busy         out  1   engine active, pipeline must stall
//   done         out  1   one-cycle pulse closing a save/restore
//   dout_valid   out  1   save stream beat valid
//   dout_ready   in   1   save stream sink ready
//   dout_data    out  32  save stream data
//   din_valid    in   1   restore stream beat valid
//   din_ready    out  1   restore stream accept
//   din_data     in   32  restore stream data
// ============================================================================
module regbank_ctx (
  input  logic        clock,
  input  logic        reset,
  input  logic        wreg,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        ctx_save,
  input  logic        ctx_restore,
  output logic        busy,
  output logic        done,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [4:0] c_LAST_IDX  = 5'd31;
  localparam logic [4:0] c_FIRST_IDX = 5'd1;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [31:0] r_regs [1:31];

  logic        w_pipe_we;
  logic        w_save_beat;
  logic        w_restore_beat;

  // Pipeline writes only land while the engine is idle; x0 is never stored.
  assign w_pipe_we      = (r_state == S_IDLE) && wreg && (write_reg != 5'd0);
  assign w_save_beat    = (r_state == S_SAVE) && dout_ready;
  assign w_restore_beat = (r_state == S_RESTORE) && din_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= 5'd0;
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pipe_we) begin
            r_regs[write_reg] <= write_data;
          end
          // Save has priority when both requests arrive together.
          if (ctx_save) begin
            r_state <= S_SAVE;
            r_idx   <= c_FIRST_IDX;
          end else if (ctx_restore) begin
            r_state <= S_RESTORE;
            r_idx   <= c_FIRST_IDX;
          end
        end
        S_SAVE: begin
          if (w_save_beat) begin
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_RESTORE: begin
          if (w_restore_beat) begin
            r_regs[r_idx] <= din_data;
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= 5'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 5'd0;
        end
      endcase
    end
  end

  // Read ports: address 0 short-circuits to zero so r_regs is never
  // indexed out of range.
  always_comb begin
    read_data1 = 32'd0;
    read_data2 = 32'd0;
    if (read_reg1 != 5'd0) begin
      read_data1 = r_regs[read_reg1];
    end
    if (read_reg2 != 5'd0) begin
      read_data2 = r_regs[read_reg2];
    end
  end

  // Stream data is taken straight from the register addressed by r_idx, so
  // it holds naturally while the sink stalls. Zero outside SAVE.
  always_comb begin
    dout_data = 32'd0;
    if (r_state == S_SAVE) begin
      dout_data = r_regs[r_idx];
    end
  end

  // Status outputs are pure decodes of the state register.
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign dout_valid = (r_state == S_SAVE);
  assign din_ready  = (r_state == S_RESTORE);

endmodule
`default_nettype wire

// File: tb/tb_regbank_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_ctx
// Purpose  : Self-checking bench for regbank_ctx. Table of write/read vectors
//            plus directed save/restore/abort sequences checked against a
//            bench-side register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_ctx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wreg = 1'b0;
  logic [4:0]  write_reg = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic [4:0]  read_reg1 = 5'd0;
  logic [4:0]  read_reg2 = 5'd0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        ctx_save = 1'b0;
  logic        ctx_restore = 1'b0;
  logic        busy;
  logic        done;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] dout_data;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] din_data = 32'd0;

  regbank_ctx dut (
    .clock      (clock),
    .reset      (reset),
    .wreg       (wreg),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .ctx_save   (ctx_save),
    .ctx_restore(ctx_restore),
    .busy       (busy),
    .done       (done),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_regs [0:31];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; reads every register through both ports.
  task automatic verify_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = i[4:0];
      read_reg2 = 5'(31 - i);
      #1;
      chk($sformatf("%s_rd1_r%0d", tag, i), read_data1, exp_regs[i]);
      chk($sformatf("%s_rd2_r%0d", tag, 31 - i), read_data2, exp_regs[31 - i]);
    end
  endtask

  // Called at posedge+1 in IDLE.
  task automatic run_save(input bit toggle, input bit both, input bit poke);
    int beats = 0;
    int busy_cyc = 0;
    int cyc = 0;
    bit seen_done = 0;
    ctx_save    = 1'b1;
    ctx_restore = both;
    dout_ready  = 1'b1;
    @(posedge clock); #1;
    ctx_save    = 1'b0;
    ctx_restore = 1'b0;
    while (!seen_done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        seen_done = 1;
        chk("save_done_busy", {31'd0, busy}, 32'd1);
        chk("save_done_valid", {31'd0, dout_valid}, 32'd0);
      end else begin
        chk("save_valid", {31'd0, dout_valid}, 32'd1);
        chk("save_din_ready", {31'd0, din_ready}, 32'd0);
        if (beats < 31) begin
          chk($sformatf("save_data_b%0d", beats + 1), dout_data, exp_regs[beats + 1]);
        end else begin
          chk("save_extra_beat", 32'(beats), 32'd30);
        end
        if (dout_ready) beats++;
      end
      @(posedge clock); #1;
      if (toggle) dout_ready = ~dout_ready;
      ctx_restore = (poke && cyc == 5);
      if (poke && cyc == 3) begin
        wreg = 1'b1; write_reg = 5'd7; write_data = 32'hFFFF_FFFF;
      end else begin
        wreg = 1'b0;
      end
    end
    wreg = 1'b0;
    ctx_restore = 1'b0;
    chk("save_done_seen", {31'd0, seen_done}, 32'd1);
    chk("save_beats", 32'(beats), 32'd31);
    if (!toggle) begin
      chk("save_busy_cycles", 32'(busy_cyc), 32'd32);
      chk("save_total_cycles", 32'(cyc), 32'd32);
    end
    @(negedge clock);
    chk("save_after_busy", {31'd0, busy}, 32'd0);
    chk("save_after_done", {31'd0, done}, 32'd0);
    chk("save_after_valid", {31'd0, dout_valid}, 32'd0);
    @(posedge clock); #1;
  endtask

  // Called at posedge+1 in IDLE. abort_after>0 asserts reset while beat
  // abort_after+1 is being presented.
  task automatic run_restore(input int abort_after);
    int beats = 0;
    int cyc = 0;
    int last_idx = 0;
    bit seen_done = 0;
    bit aborted = 0;
    ctx_restore = 1'b1;
    @(posedge clock); #1;
    ctx_restore = 1'b0;
    while (!seen_done && cyc < 300) begin
      din_valid  = (abort_after > 0) ? 1'b1 : (cyc % 3 != 1);
      din_data   = 32'hA000_0000 + 32'(beats + 1);
      read_reg2  = last_idx[4:0];
      wreg       = (cyc == 4);
      write_reg  = 5'd7;
      write_data = 32'hFFFF_FFFF;
      if (abort_after > 0 && beats == abort_after) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("abort_din_ready", {31'd0, din_ready}, 32'd0);
        chk("abort_dout_data", dout_data, 32'd0);
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        aborted = 1;
        break;
      end
      @(negedge clock);
      if (last_idx != 0) begin
        chk($sformatf("restore_rdback_r%0d", last_idx), read_data2, exp_regs[last_idx]);
      end
      if (done) begin
        seen_done = 1;
        chk("restore_done_busy", {31'd0, busy}, 32'd1);
      end else begin
        chk("restore_din_ready", {31'd0, din_ready}, 32'd1);
        chk("restore_dout_valid", {31'd0, dout_valid}, 32'd0);
        if (din_valid) begin
          if (beats < 31) begin
            exp_regs[beats + 1] = din_data;
            last_idx = beats + 1;
          end
          beats++;
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    wreg = 1'b0;
    din_valid = 1'b0;
    if (!aborted) begin
      chk("restore_done_seen", {31'd0, seen_done}, 32'd1);
      chk("restore_beats", 32'(beats), 32'd31);
      @(negedge clock);
      chk("restore_after_busy", {31'd0, busy}, 32'd0);
      chk("restore_after_done", {31'd0, done}, 32'd0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;

    //          we    wa     wd             ra1    ra2    e1 (pre-edge)  e2 (pre-edge)
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF,  5'd5,  5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234,  5'd5,  5'd0,  32'hDEADBEEF,  32'h0};
    vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D,  5'd0,  5'd5,  32'h0,         32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd31, 32'h11111111,  5'd31, 5'd5,  32'hCAFEF00D,  32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001,  5'd31, 5'd1,  32'hCAFEF00D,  32'h0};
    vecs[5] = '{1'b0, 5'd1,  32'h0,         5'd1,  5'd0,  32'h00000001,  32'h0};
    vecs[6] = '{1'b1, 5'd5,  32'h0,         5'd5,  5'd31, 32'hDEADBEEF,  32'hCAFEF00D};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h0,         32'h0};

    // Reset state
    read_reg1 = 5'd5;
    read_reg2 = 5'd31;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_dout_data", dout_data, 32'd0);
    chk("rst_rd1", read_data1, 32'd0);
    chk("rst_rd2", read_data2, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Table-driven pipeline writes / reads
    for (int v = 0; v < 8; v++) begin
      wreg       = vecs[v].we;
      write_reg  = vecs[v].wa;
      write_data = vecs[v].wd;
      read_reg1  = vecs[v].ra1;
      read_reg2  = vecs[v].ra2;
      @(negedge clock);
      chk($sformatf("vec%0d_rd1", v), read_data1, vecs[v].e1);
      chk($sformatf("vec%0d_rd2", v), read_data2, vecs[v].e2);
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
      @(posedge clock); #1;
      if (vecs[v].we && vecs[v].wa != 5'd0) exp_regs[vecs[v].wa] = vecs[v].wd;
    end
    wreg = 1'b0;
    verify_all("table");

    // Load rN = N * 0x01010101
    for (int n = 1; n < 32; n++) begin
      wreg = 1'b1;
      write_reg = n[4:0];
      write_data = 32'(n) * 32'h0101_0101;
      @(posedge clock); #1;
      exp_regs[n] = 32'(n) * 32'h0101_0101;
    end
    wreg = 1'b0;
    verify_all("load");

    // Save, no backpressure; wreg and restore request during busy ignored
    run_save(1'b0, 1'b0, 1'b1);
    verify_all("save1");

    // Save with dout_ready toggling
    run_save(1'b1, 1'b0, 1'b0);

    // Restore with valid gaps and wreg pulse during busy
    run_restore(0);
    verify_all("restore");

    // Save and restore requested together: save wins, no reg modified
    run_save(1'b0, 1'b1, 1'b0);
    verify_all("both");

    // Reset asserted while beat 10 of a restore is presented
    run_restore(9);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_hold_done", {31'd0, done}, 32'd0);
    chk("abort_hold_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    verify_all("abort");
    run_save(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
